// File: rtl/spi_mem_target.sv
// SPI mode-0 serial RAM target, all pins oversampled on clk.
// Define SPI_TARGET_FAST_READ_EN to accept fast read (0x0B) with 8 dummy clocks.
module spi_mem_target #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              busy,
    output logic              cmd_err,
    output logic              wr_strobe,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic              bd_we,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RDATA, WDATA, IGNORE, DUMMY
    } state_t;

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_FAST = 2'd2;

    logic [7:0] mem [MEM_BYTES];

    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, vld_q;
    logic       sclk_prev_q, cs_prev_q, armed_q;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        op_q, op_d;
    logic              pend_q, pend_d;
    logic              cmd_err_q, wr_strobe_q;
    logic [7:0]        bd_rdata_q;

    logic              sclk_s, cs_s, mosi_s;
    logic              rise, fall, cs_fall, cs_rise;
    logic              spi_we, bad_cmd;
    logic [7:0]        rx_next;
    logic [ADDR_W-1:0] addr_next, addr_inc;

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign rise      = sclk_s & ~sclk_prev_q;
    assign fall      = ~sclk_s & sclk_prev_q;
    // A frame only starts once cs_n has been seen high since reset
    assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign rx_next   = {rx_q[6:0], mosi_s};
    assign addr_next = {addr_q[ADDR_W-2:0], mosi_s};
    assign addr_inc  = addr_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        op_d    = op_q;
        pend_d  = pend_q;
        spi_we  = 1'b0;
        bad_cmd = 1'b0;
        if (cs_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            if (rx_next == 8'h03) begin
                                op_d    = OP_RD;
                                state_d = ADDR;
                            end else if (rx_next == 8'h02) begin
                                op_d    = OP_WR;
                                state_d = ADDR;
                            end
`ifdef SPI_TARGET_FAST_READ_EN
                            else if (rx_next == 8'h0B) begin
                                op_d    = OP_FAST;
                                state_d = ADDR;
                            end
`endif
                            else begin
                                state_d = IGNORE;
                                bad_cmd = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (rise) begin
                        addr_d = addr_next;
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d  = '0;
                            pend_d = 1'b0;
                            if (op_q == OP_RD) begin
                                tx_d    = mem[addr_next];
                                state_d = RDATA;
                            end else if (op_q == OP_FAST) begin
                                state_d = DUMMY;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                DUMMY: begin
                    if (rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d   = '0;
                            tx_d    = mem[addr_q];
                            state_d = RDATA;
                        end
                    end
                end
                RDATA: begin
                    // The fall that closes the last header clock must not shift
                    if (rise) begin
                        cnt_d  = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
                        pend_d = 1'b1;
                    end else if (fall && pend_q) begin
                        pend_d = 1'b0;
                        if (cnt_q == 5'd0) begin
                            addr_d = addr_inc;
                            tx_d   = mem[addr_inc];
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                WDATA: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d  = '0;
                            spi_we = 1'b1;
                            addr_d = addr_inc;
                        end
                    end
                end
                IGNORE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_sync_q   <= 2'b11;
            cs_prev_q   <= 1'b1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            op_q        <= OP_WR;
            pend_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            bd_rdata_q  <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            sclk_prev_q <= sclk_s;
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            cs_prev_q   <= cs_s;
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            vld_q       <= {vld_q[0], 1'b1};
            armed_q     <= armed_q | (vld_q[1] & cs_s);
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            pend_q      <= pend_d;
            cmd_err_q   <= bad_cmd;
            wr_strobe_q <= spi_we;
            bd_rdata_q  <= mem[bd_addr];
        end
    end

    // Memory is not reset; SPI write has priority over backdoor
    always_ff @(posedge clk) begin
        if (spi_we) begin
            mem[addr_q] <= rx_next;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

    assign miso      = (state_q == RDATA) & tx_q[7];
    assign miso_oe   = armed_q & ~cs_s;
    assign busy      = armed_q & ~cs_s;
    assign cmd_err   = cmd_err_q;
    assign wr_strobe = wr_strobe_q;
    assign bd_rdata  = bd_rdata_q;

endmodule

// File: tb/tb_spi_mem_target.sv
// Bench for spi_mem_target: table-driven SPI frames with a read scoreboard
// plus hand-written sequences for aborts, bad commands, reset and collisions.
module tb_spi_mem_target;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi;
    logic       miso, miso_oe, busy, cmd_err, wr_strobe;
    logic [7:0] bd_addr, bd_wdata, bd_rdata;
    logic       bd_we;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int nz_cnt = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  addr;
        int          n;
        logic [31:0] data;
        bit          rd;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } bdv_t;

    spi_mem_target dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .busy(busy), .cmd_err(cmd_err),
        .wr_strobe(wr_strobe), .bd_addr(bd_addr), .bd_we(bd_we),
        .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (cmd_err) err_cnt++;
        if ({miso, miso_oe, busy, cmd_err, wr_strobe} != 5'b0) nz_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input bit coll, output logic r);
        mosi = b;
        repeat (5) @(negedge clk);
        r = miso;
        sclk = 1'b1;
        if (coll) bd_we = 1'b1;
        repeat (3) @(negedge clk);
        bd_we = 1'b0;
        repeat (2) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] t, input bit coll, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(t[i], coll && (i == 0), b);
            r[i] = b;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] a);
        logic [7:0] r;
        spi_byte(op, 0, r);
        spi_byte(8'h00, 0, r);
        spi_byte(8'h00, 0, r);
        spi_byte(a, 0, r);
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_wdata = d;
        bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
        bd_addr = a;
        repeat (2) @(negedge clk);
        d = bd_rdata;
    endtask

    task automatic do_frame(input logic [7:0] op, input logic [7:0] a, input int n,
                            input logic [31:0] d, input bit rd, input int dummy);
        logic [7:0] r, e;
        logic       b, acc;
        logic [31:0] dv;
        dv = d;
        cs_begin();
        send_hdr(op, a);
        acc = 1'b0;
        for (int k = 0; k < dummy; k++) begin
            spi_bit(1'b1, 0, b);
            acc = acc | b;
        end
        if (dummy > 0) check("dummy_miso", {31'd0, acc}, 32'd0);
        if (rd) begin
            for (int k = 0; k < n; k++) exp_q.push_back(dv[31-8*k -: 8]);
            for (int k = 0; k < n; k++) begin
                spi_byte(8'h00, 0, r);
                e = exp_q.pop_front();
                check($sformatf("rd_%02h_b%0d", a, k), {24'd0, r}, {24'd0, e});
            end
        end else begin
            for (int k = 0; k < n; k++) spi_byte(dv[31-8*k -: 8], 0, r);
        end
        cs_end();
    endtask

    vec_t vecs [4];
    bdv_t bdv  [5];

    initial begin
        logic [7:0] r;
        logic       b;
        int w0, e0, z0;

        vecs[0] = '{8'h03, 8'h10, 4, 32'h11223344, 1'b1};
        vecs[1] = '{8'h02, 8'hFE, 3, 32'hAABBCC00, 1'b0};
        vecs[2] = '{8'h03, 8'hFE, 3, 32'hAABBCC00, 1'b1};
        vecs[3] = '{8'h03, 8'h11, 2, 32'h22330000, 1'b1};
        bdv[0] = '{8'hFE, 8'hAA};
        bdv[1] = '{8'hFF, 8'hBB};
        bdv[2] = '{8'h00, 8'hCC};
        bdv[3] = '{8'h10, 8'h11};
        bdv[4] = '{8'h13, 8'h44};

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        bd_addr = 8'h00; bd_we = 1'b0; bd_wdata = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_outs", {27'd0, miso, miso_oe, busy, cmd_err, wr_strobe}, 32'd0);
        check("reset_bd_rdata", {24'd0, bd_rdata}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_busy", {30'd0, busy, miso_oe}, 32'd0);

        bd_write(8'h10, 8'h11);
        bd_write(8'h11, 8'h22);
        bd_write(8'h12, 8'h33);
        bd_write(8'h13, 8'h44);
        bd_write(8'h20, 8'h5A);

        for (int i = 0; i < 4; i++) begin
            w0 = wr_cnt;
            do_frame(vecs[i].op, vecs[i].addr, vecs[i].n, vecs[i].data, vecs[i].rd, 0);
            if (!vecs[i].rd) check("wr_strobes", wr_cnt - w0, vecs[i].n);
        end
        for (int i = 0; i < 5; i++) begin
            bd_read(bdv[i].addr, r);
            check($sformatf("bd_%02h", bdv[i].addr), {24'd0, r}, {24'd0, bdv[i].exp});
        end

        // Aborted write: 5 bits of data then deselect
        w0 = wr_cnt;
        cs_begin();
        send_hdr(8'h02, 8'h20);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 5; k++) spi_bit(1'b1, 0, b);
        cs_end();
        check("abort_no_strobe", wr_cnt - w0, 32'd0);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        bd_read(8'h20, r);
        check("abort_mem20", {24'd0, r}, 32'h5A);
        do_frame(8'h03, 8'h20, 1, 32'h5A000000, 1'b1, 0);

        // Unsupported command
        e0 = err_cnt;
        cs_begin();
        spi_byte(8'h9F, 0, r);
        spi_byte(8'hFF, 0, r);
        check("bad_cmd_miso0", {24'd0, r}, 32'd0);
        spi_byte(8'hFF, 0, r);
        check("bad_cmd_miso1", {24'd0, r}, 32'd0);
        cs_end();
        check("bad_cmd_err", err_cnt - e0, 32'd1);
        do_frame(8'h03, 8'h12, 1, 32'h33000000, 1'b1, 0);

        // Reset during a read frame, released while still selected
        cs_begin();
        spi_byte(8'h03, 0, r);
        for (int k = 0; k < 4; k++) spi_bit(1'b0, 0, b);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        z0 = nz_cnt;
        for (int k = 0; k < 12; k++) spi_bit(k == 7, 0, b);
        spi_byte(8'h00, 0, r);
        spi_byte(8'h00, 0, r);
        check("rst_mid_quiet", nz_cnt - z0, 32'd0);
        cs_end();
        do_frame(8'h03, 8'h10, 1, 32'h11000000, 1'b1, 0);

        // SPI write and backdoor write to the same byte in the same cycle
        w0 = wr_cnt;
        bd_addr = 8'h40;
        bd_wdata = 8'h99;
        cs_begin();
        send_hdr(8'h02, 8'h40);
        spi_byte(8'h77, 1, r);
        cs_end();
        check("coll_strobe", wr_cnt - w0, 32'd1);
        bd_read(8'h40, r);
        check("coll_mem40", {24'd0, r}, 32'h77);

`ifdef SPI_TARGET_FAST_READ_EN
        e0 = err_cnt;
        do_frame(8'h0B, 8'h40, 1, 32'h77000000, 1'b1, 8);
        check("fast_no_err", err_cnt - e0, 32'd0);
`else
        e0 = err_cnt;
        cs_begin();
        spi_byte(8'h0B, 0, r);
        spi_byte(8'h00, 0, r);
        check("fast_off_miso", {24'd0, r}, 32'd0);
        cs_end();
        check("fast_off_err", err_cnt - e0, 32'd1);
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
